// File: rtl/cr_kme_int_ctrl.sv
// KME interrupt-status controller: edge-detected sticky status/overflow, W1C, mask; 2-cycle set-to-IRQ latency, W1C always accepted.
// Define CR_KME_INT_COALESCE_EN to build the IDLE/ASSERT/HOLDOFF hold-off FSM on kme_interrupt.
module cr_kme_int_ctrl #(
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_gcm_tag_fail_int,
  input  logic                 set_txc_bp_int,
  input  logic [7:0]           set_rsm_is_backpressuring,
  input  logic [9:0]           int_mask,
  input  logic [9:0]           int_force,
  input  logic                 int_w1c_valid,
  input  logic [9:0]           int_w1c_data,
  input  logic [HOLDOFF_W-1:0] holdoff_cfg,
  output logic [9:0]           int_status,
  output logic [9:0]           int_overflow,
  output logic                 int_pending,
  output logic                 kme_interrupt
);

  logic [9:0] src;
  logic [9:0] src_q;
  logic [9:0] evt;
  logic [9:0] clr;

  assign src = {set_rsm_is_backpressuring, set_txc_bp_int, set_gcm_tag_fail_int};
  assign evt = (src & ~src_q) | int_force;
  assign clr = int_w1c_valid ? int_w1c_data : '0;

  // Overflow compares against pre-clear status, so an event in the clear cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q        <= '0;
      int_status   <= '0;
      int_overflow <= '0;
    end else begin
      src_q        <= src;
      int_status   <= (int_status & ~clr) | evt;
      int_overflow <= (int_overflow & ~clr) | (evt & int_status);
    end
  end

  assign int_pending = |(int_status & ~int_mask);

`ifdef CR_KME_INT_COALESCE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [HOLDOFF_W-1:0] cnt_q;
  logic [HOLDOFF_W-1:0] cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (int_pending) state_d = ASSERT;
      end
      ASSERT: begin
        if (!int_pending) begin
          if (holdoff_cfg == '0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = holdoff_cfg;
          end
        end
      end
      HOLDOFF: begin
        // Pending sources wait here; IDLE picks them up one cycle after the count expires.
        cnt_d = cnt_q - HOLDOFF_W'(1);
        if (cnt_q == HOLDOFF_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      kme_interrupt <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      kme_interrupt <= (state_d == ASSERT);
    end
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff_cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kme_interrupt <= 1'b0;
    else        kme_interrupt <= int_pending;
  end
`endif

endmodule

// File: tb/tb_cr_kme_int_ctrl.sv
`timescale 1ns/1ps
module tb_cr_kme_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        set_gcm_tag_fail_int;
  logic        set_txc_bp_int;
  logic [7:0]  set_rsm_is_backpressuring;
  logic [9:0]  int_mask;
  logic [9:0]  int_force;
  logic        int_w1c_valid;
  logic [9:0]  int_w1c_data;
  logic [15:0] holdoff_cfg;
  logic [9:0]  int_status;
  logic [9:0]  int_overflow;
  logic        int_pending;
  logic        kme_interrupt;

  cr_kme_int_ctrl #(.HOLDOFF_W(16)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .set_gcm_tag_fail_int      (set_gcm_tag_fail_int),
    .set_txc_bp_int            (set_txc_bp_int),
    .set_rsm_is_backpressuring (set_rsm_is_backpressuring),
    .int_mask                  (int_mask),
    .int_force                 (int_force),
    .int_w1c_valid             (int_w1c_valid),
    .int_w1c_data              (int_w1c_data),
    .holdoff_cfg               (holdoff_cfg),
    .int_status                (int_status),
    .int_overflow              (int_overflow),
    .int_pending               (int_pending),
    .kme_interrupt             (kme_interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] st;
    logic [9:0] ov;
    logic       pend;
    logic       kint;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected response for the cycle that is d edges after now.
  task automatic push(input int d, input string nm, input logic [9:0] st, input logic [9:0] ov,
                      input logic pend, input logic kint);
    exp_t e;
    e.cyc  = cyc + d;
    e.st   = st;
    e.ov   = ov;
    e.pend = pend;
    e.kint = kint;
    sbq.push_back(e);
    nmq.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due in the current cycle, mid-cycle.
  exp_t  me;
  string mnm;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me  = sbq.pop_front();
      mnm = nmq.pop_front();
      checks = checks + 1;
      if (me.cyc < cyc) begin
        errors = errors + 1;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", mnm, me.cyc, cyc);
      end else if (int_status !== me.st || int_overflow !== me.ov ||
                   int_pending !== me.pend || kme_interrupt !== me.kint) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d: got st=%h ov=%h pend=%b irq=%b, want st=%h ov=%h pend=%b irq=%b",
                 mnm, cyc, int_status, int_overflow, int_pending, kme_interrupt,
                 me.st, me.ov, me.pend, me.kint);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_gcm_tag_fail_int = 1'b0;
    set_txc_bp_int = 1'b1;
    set_rsm_is_backpressuring = 8'h00;
    int_mask = 10'h000;
    int_force = 10'h000;
    int_w1c_valid = 1'b0;
    int_w1c_data = 10'h000;
    holdoff_cfg = 16'd0;

    repeat (3) tick();
    push(0, "reset", 10'h000, 10'h000, 1'b0, 1'b0);
    tick();

    // Source held high across reset release: exactly one event.
    rst_n = 1'b1;
    push(1, "rst_rel_status", 10'h002, 10'h000, 1'b1, 1'b0);
    push(2, "rst_rel_irq",    10'h002, 10'h000, 1'b1, 1'b1);
    push(3, "held_one_event", 10'h002, 10'h000, 1'b1, 1'b1);
    repeat (3) tick();
    set_txc_bp_int = 1'b0;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h002;
    push(1, "clr_txc",     10'h000, 10'h000, 1'b0, 1'b1);
    push(2, "clr_txc_irq", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); int_w1c_valid = 1'b0;
    tick();

    // Two pulses on gcm -> overflow, then W1C clears both.
    set_gcm_tag_fail_int = 1'b1;
    push(1, "gcm_first",   10'h001, 10'h000, 1'b1, 1'b0);
    push(2, "gcm_irq",     10'h001, 10'h000, 1'b1, 1'b1);
    push(3, "gcm_ovf",     10'h001, 10'h001, 1'b1, 1'b1);
    push(4, "w1c_gcm",     10'h000, 10'h000, 1'b0, 1'b1);
    push(5, "w1c_gcm_irq", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); set_gcm_tag_fail_int = 1'b0;
    tick(); set_gcm_tag_fail_int = 1'b1;
    tick(); set_gcm_tag_fail_int = 1'b0; int_w1c_valid = 1'b1; int_w1c_data = 10'h001;
    tick(); int_w1c_valid = 1'b0;
    tick(); tick();

    // Set and clear on the same bit: set wins, no overflow.
    set_rsm_is_backpressuring = 8'h20;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h080;
    push(1, "set_wins",     10'h080, 10'h000, 1'b1, 1'b0);
    push(2, "set_wins_irq", 10'h080, 10'h000, 1'b1, 1'b1);
    tick(); int_w1c_valid = 1'b0;
    tick();
    set_rsm_is_backpressuring = 8'h00;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h080;
    push(1, "clr7",     10'h000, 10'h000, 1'b0, 1'b1);
    push(2, "clr7_irq", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); int_w1c_valid = 1'b0;
    tick(); tick();

    // Forced events on bit 9, second one overflows.
    int_force = 10'h200;
    push(1, "force_set", 10'h200, 10'h000, 1'b1, 1'b0);
    push(2, "force_ovf", 10'h200, 10'h200, 1'b1, 1'b1);
    tick(); tick();
    int_force = 10'h000;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h200;
    push(1, "w1c_force",     10'h000, 10'h000, 1'b0, 1'b1);
    push(2, "w1c_force_irq", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); int_w1c_valid = 1'b0;
    tick(); tick();

    // Fully masked sources record status but do not interrupt; unmask is immediate.
    int_mask = 10'h3FF;
    set_gcm_tag_fail_int = 1'b1; set_txc_bp_int = 1'b1; set_rsm_is_backpressuring = 8'hFF;
    push(1, "mask_all", 10'h3FF, 10'h000, 1'b0, 1'b0);
    tick();
    set_gcm_tag_fail_int = 1'b0; set_txc_bp_int = 1'b0; set_rsm_is_backpressuring = 8'h00;
    tick();
    push(0, "mask_hold", 10'h3FF, 10'h000, 1'b0, 1'b0);
    tick();
    int_mask = 10'h3FB;
    push(0, "unmask_pend", 10'h3FF, 10'h000, 1'b1, 1'b0);
    push(1, "unmask_irq",  10'h3FF, 10'h000, 1'b1, 1'b1);
    tick();
    int_mask = 10'h000;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h3FF;
    push(1, "clr_all",     10'h000, 10'h000, 1'b0, 1'b1);
    push(2, "clr_all_irq", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); int_w1c_valid = 1'b0;
    tick(); tick();

    // Asynchronous reset takes effect mid-cycle.
    int_force = 10'h010;
    tick();
    int_force = 10'h000;
    #2 rst_n = 1'b0;
    push(0, "async_rst", 10'h000, 10'h000, 1'b0, 1'b0);
    tick(); rst_n = 1'b1;
    tick(); tick();

`ifdef CR_KME_INT_COALESCE_EN
    // Hold-off of 5: low for 6 cycles after ASSERT exit, then re-assert.
    holdoff_cfg = 16'd5;
    int_force = 10'h001;
    push(2,  "co_assert",     10'h001, 10'h000, 1'b1, 1'b1);
    push(3,  "co_clr",        10'h000, 10'h000, 1'b0, 1'b1);
    push(4,  "co_hold_start", 10'h001, 10'h000, 1'b1, 1'b0);
    push(9,  "co_hold_end",   10'h001, 10'h000, 1'b1, 1'b0);
    push(10, "co_reassert",   10'h001, 10'h000, 1'b1, 1'b1);
    tick(); int_force = 10'h000;
    tick(); int_w1c_valid = 1'b1; int_w1c_data = 10'h001;
    tick(); int_w1c_valid = 1'b0; int_force = 10'h001;
    tick(); int_force = 10'h000;
    repeat (6) tick();

    // Hold-off of 0: one-cycle gap.
    holdoff_cfg = 16'd0;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h001;
    push(1, "co0_clr",      10'h000, 10'h000, 1'b0, 1'b1);
    push(2, "co0_gap",      10'h001, 10'h000, 1'b1, 1'b0);
    push(3, "co0_reassert", 10'h001, 10'h000, 1'b1, 1'b1);
    tick(); int_w1c_valid = 1'b0; int_force = 10'h001;
    tick(); int_force = 10'h000;
    tick();

    // Reset during HOLDOFF returns the FSM to IDLE.
    holdoff_cfg = 16'd5;
    int_w1c_valid = 1'b1; int_w1c_data = 10'h001;
    tick(); int_w1c_valid = 1'b0; int_force = 10'h008;
    tick(); int_force = 10'h000;
    push(0, "co_pre_rst", 10'h008, 10'h000, 1'b1, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    push(0, "co_rst_hold", 10'h000, 10'h000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; int_force = 10'h001;
    push(1, "co_post_rst",     10'h001, 10'h000, 1'b1, 1'b0);
    push(2, "co_post_rst_irq", 10'h001, 10'h000, 1'b1, 1'b1);
    tick(); int_force = 10'h000;
`endif

    for (int i = 0; i < 50 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations never reached", sbq.size());
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
